// File: rtl/dot_pkg.sv
// ---------------------------------------------------------------------------
// dot_pkg
//   Shared definitions for the dot-product batch scheduler: default widths
//   and the controller state encoding.
// ---------------------------------------------------------------------------
package dot_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 4;   // N = 2**ADDRESS_WIDTH entries
    localparam int unsigned DEF_DATA_WIDTH    = 12;  // packed operand vector width
    localparam int unsigned DEF_VALUE_WIDTH   = 4;   // width of one element in a vector

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } dot_state_e;

endpackage

// File: rtl/dot_addr_cnt.sv
// ---------------------------------------------------------------------------
// dot_addr_cnt
//   Entry address counter plus written-entry count for one batch.
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-high reset
//     clr_i          clear address and count (batch start)
//     addr_inc_i     advance address; saturates at N-1 (never wraps)
//     cnt_inc_i      increment written-entry count; saturates at N
//     addr_o         current entry address
//     count_o        entries written this batch (0..N)
//     last_o         address is at N-1
// ---------------------------------------------------------------------------
module dot_addr_cnt
    import dot_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     addr_inc_i,
    input  logic                     cnt_inc_i,
    output logic [ADDRESS_WIDTH-1:0] addr_o,
    output logic [ADDRESS_WIDTH:0]   count_o,
    output logic                     last_o
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST  = '1;
    localparam logic [ADDRESS_WIDTH:0]   COUNT_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH:0]   count_q, count_d;

    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (clr_i) begin
            addr_d  = '0;
            count_d = '0;
        end else begin
            if (addr_inc_i && (addr_q != ADDR_LAST)) begin
                addr_d = addr_q + 1'b1;
            end
            if (cnt_inc_i && (count_q != COUNT_FULL)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign addr_o  = addr_q;
    assign count_o = count_q;
    assign last_o  = (addr_q == ADDR_LAST);

endmodule

// File: rtl/dot_scheduler.sv
// ---------------------------------------------------------------------------
// dot_scheduler
//   Walks all N = 2**ADDRESS_WIDTH entries: reads operands, launches the
//   dot-product datapath, waits for its result and writes it back.
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     start, abort                begin a batch / cancel the running batch
//     host_wr, host_wr_ok         host operand-memory write request / grant
//     op_rd_en, op_rd_addr        operand-memory read (1-cycle latency)
//     dp_valid, dp_ready          launch handshake to the datapath
//     res_valid, res_ready        result handshake from the datapath
//     res_wr_en, res_wr_addr      result-memory write strobe
//     busy                        batch in progress (any state but IDLE)
//     done_writing, err           one-cycle pulses
//     count                       entries written this batch
// ---------------------------------------------------------------------------
module dot_scheduler
    import dot_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     host_wr,
    output logic                     host_wr_ok,
    output logic                     op_rd_en,
    output logic [ADDRESS_WIDTH-1:0] op_rd_addr,
    output logic                     dp_valid,
    input  logic                     dp_ready,
    input  logic                     res_valid,
    output logic                     res_ready,
    output logic                     res_wr_en,
    output logic [ADDRESS_WIDTH-1:0] res_wr_addr,
    output logic                     busy,
    output logic                     done_writing,
    output logic                     err,
    output logic [ADDRESS_WIDTH:0]   count
);

    // DATA_WIDTH only travels with the operand memories; reject nonsense here.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("dot_scheduler: DATA_WIDTH must be at least 1");
    end

    dot_state_e               state_q;
    logic                     op_rd_en_q;
    logic [ADDRESS_WIDTH-1:0] op_rd_addr_q;
    logic                     dp_valid_q;
    logic                     res_ready_q;
    logic                     res_wr_en_q;
    logic [ADDRESS_WIDTH-1:0] res_wr_addr_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;

    logic                     cnt_clr;
    logic                     cnt_inc;
    logic                     addr_inc;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic                     addr_last;

    // Counter controls mirror the FSM transitions below so that count
    // reflects writes already issued and addr the entry being processed.
    always_comb begin
        cnt_clr   = (state_q == ST_IDLE) && start;
        cnt_inc   = (state_q == ST_WAIT) && res_valid && !abort;
        addr_inc  = (state_q == ST_WRITE) && !abort;
        addr_next = addr + 1'b1;
    end

    dot_addr_cnt #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_addr_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (cnt_clr),
        .addr_inc_i (addr_inc),
        .cnt_inc_i  (cnt_inc),
        .addr_o     (addr),
        .count_o    (count),
        .last_o     (addr_last)
    );

    // Outputs are registered from the transition being taken, so each one is
    // valid for exactly the cycles spent in its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_rd_en_q    <= 1'b0;
            op_rd_addr_q  <= '0;
            dp_valid_q    <= 1'b0;
            res_ready_q   <= 1'b0;
            res_wr_en_q   <= 1'b0;
            res_wr_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            op_rd_en_q  <= 1'b0;
            res_wr_en_q <= 1'b0;
            done_q      <= 1'b0;
            // start and host_wr together while busy still give one pulse.
            err_q       <= busy_q && (start || host_wr);

            if ((state_q != ST_IDLE) && abort) begin
                state_q     <= ST_IDLE;
                dp_valid_q  <= 1'b0;
                res_ready_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q      <= ST_READ;
                            op_rd_en_q   <= 1'b1;
                            op_rd_addr_q <= '0;
                            busy_q       <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        state_q    <= ST_LAUNCH;
                        dp_valid_q <= 1'b1;
                    end
                    ST_LAUNCH: begin
                        if (dp_ready) begin
                            state_q     <= ST_WAIT;
                            dp_valid_q  <= 1'b0;
                            res_ready_q <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (res_valid) begin
                            state_q       <= ST_WRITE;
                            res_ready_q   <= 1'b0;
                            res_wr_en_q   <= 1'b1;
                            res_wr_addr_q <= addr;
                        end
                    end
                    ST_WRITE: begin
                        if (addr_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= ST_READ;
                            op_rd_en_q   <= 1'b1;
                            op_rd_addr_q <= addr_next;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        dp_valid_q  <= 1'b0;
                        res_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign host_wr_ok   = host_wr && !busy_q;
    assign op_rd_en     = op_rd_en_q;
    assign op_rd_addr   = op_rd_addr_q;
    assign dp_valid     = dp_valid_q;
    assign res_ready    = res_ready_q;
    assign res_wr_en    = res_wr_en_q;
    assign res_wr_addr  = res_wr_addr_q;
    assign busy         = busy_q;
    assign done_writing = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_dot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dot_scheduler
//   Directed bench for dot_scheduler with N = 16 entries.
// ---------------------------------------------------------------------------
module tb_dot_scheduler;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          host_wr;
    logic          host_wr_ok;
    logic          op_rd_en;
    logic [AW-1:0] op_rd_addr;
    logic          dp_valid;
    logic          dp_ready;
    logic          res_valid;
    logic          res_ready;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;
    logic          busy;
    logic          done_writing;
    logic          err;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_errors = 0;
    int wr_pulses = 0;
    int done_cycles = 0;
    int err_cycles = 0;
    int exp_wr_addr = 0;

    dot_scheduler #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .host_wr      (host_wr),
        .host_wr_ok   (host_wr_ok),
        .op_rd_en     (op_rd_en),
        .op_rd_addr   (op_rd_addr),
        .dp_valid     (dp_valid),
        .dp_ready     (dp_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_wr_en    (res_wr_en),
        .res_wr_addr  (res_wr_addr),
        .busy         (busy),
        .done_writing (done_writing),
        .err          (err),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result writes must come out in address order 0..N-1 within a batch.
    always @(negedge clk) begin
        if (res_wr_en === 1'b1) begin
            check("wr_addr", {28'd0, res_wr_addr}, exp_wr_addr);
            exp_wr_addr++;
            wr_pulses++;
        end
        if (done_writing === 1'b1) done_cycles++;
        if (err === 1'b1) err_cycles++;
    end

    // Runs one batch. Iteration k observes outputs after the k-th rising edge,
    // edge 1 being the one that samples start. Returns the k at which
    // done_writing is seen (-1 if aborted or out of budget).
    task automatic run_batch(input int dly_entry, input int hw_entry, input int abort_entry,
                             input int restart_k, input bit hw_with_start,
                             output int done_k, output int vrun);
        int cur;
        int dly_left;
        cur = -1;
        dly_left = 0;
        vrun = 0;
        done_k = -1;
        wr_pulses = 0;
        done_cycles = 0;
        err_cycles = 0;
        exp_wr_addr = 0;
        start = 1'b1;
        host_wr = hw_with_start;
        dp_ready = 1'b1;
        res_valid = 1'b1;
        if (hw_with_start) begin
            #1 check("hw_ok_idle_start", {31'd0, host_wr_ok}, 1);
        end
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            host_wr = 1'b0;
            abort = 1'b0;
            dp_ready = 1'b1;
            if (done_writing) begin
                done_k = k;
                break;
            end
            if (!busy) break;
            if (op_rd_en) cur = int'(op_rd_addr);
            if (op_rd_en && cur == dly_entry) begin
                dly_left = 3;
                dp_ready = 1'b0;
            end
            if (dp_valid && cur == dly_entry) begin
                vrun++;
                check("rd_addr_hold", {28'd0, op_rd_addr}, dly_entry);
                if (dly_left > 0) begin
                    dly_left--;
                    dp_ready = 1'b0;
                end
            end
            if (op_rd_en && cur == hw_entry) begin
                host_wr = 1'b1;
                #1 check("hw_ok_busy", {31'd0, host_wr_ok}, 0);
            end
            if (res_ready && cur == abort_entry) abort = 1'b1;
            if (k == restart_k) start = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dk;
        int vr;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        host_wr = 1'b0;
        dp_ready = 1'b0;
        res_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",        {31'd0, busy},         0);
        check("rst_op_rd_en",    {31'd0, op_rd_en},     0);
        check("rst_op_rd_addr",  {28'd0, op_rd_addr},   0);
        check("rst_dp_valid",    {31'd0, dp_valid},     0);
        check("rst_res_ready",   {31'd0, res_ready},    0);
        check("rst_res_wr_en",   {31'd0, res_wr_en},    0);
        check("rst_res_wr_addr", {28'd0, res_wr_addr},  0);
        check("rst_done",        {31'd0, done_writing}, 0);
        check("rst_err",         {31'd0, err},          0);
        check("rst_count",       {27'd0, count},        0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Full-speed batch: 4 cycles per entry plus DONE.
        run_batch(-1, -1, -1, -1, 1'b0, dk, vr);
        check("full_done_k",   dk, 65);
        check("full_writes",   wr_pulses, 16);
        check("full_count",    {27'd0, count}, 16);
        check("full_done_cnt", done_cycles, 1);
        check("full_err_cnt",  err_cycles, 0);
        @(negedge clk);
        #1;
        check("full_idle_busy",  {31'd0, busy}, 0);
        check("full_idle_count", {27'd0, count}, 16);

        // Datapath stalls entry 5 for three cycles.
        run_batch(5, -1, -1, -1, 1'b0, dk, vr);
        check("stall_vrun",    vr, 4);
        check("stall_done_k",  dk, 68);
        check("stall_writes",  wr_pulses, 16);
        check("stall_count",   {27'd0, count}, 16);
        @(negedge clk);
        #1;

        // Host write during the batch is refused and flagged.
        run_batch(-1, 7, -1, -1, 1'b0, dk, vr);
        check("hwbusy_err_cnt", err_cycles, 1);
        check("hwbusy_done_k",  dk, 65);
        check("hwbusy_writes",  wr_pulses, 16);
        @(negedge clk);
        #1;
        host_wr = 1'b1;
        #1 check("hwidle_ok", {31'd0, host_wr_ok}, 1);
        @(negedge clk);
        #1;
        host_wr = 1'b0;
        check("hwidle_err", {31'd0, err}, 0);
        check("hwidle_busy", {31'd0, busy}, 0);

        // Abort while waiting on the result of entry 9.
        run_batch(-1, -1, 9, -1, 1'b0, dk, vr);
        check("abort_done_k",   dk, -1);
        check("abort_busy",     {31'd0, busy}, 0);
        check("abort_count",    {27'd0, count}, 9);
        check("abort_writes",   wr_pulses, 9);
        check("abort_done_cnt", done_cycles, 0);
        check("abort_res_rdy",  {31'd0, res_ready}, 0);

        // Fresh start after abort, with a host write in the same IDLE cycle.
        run_batch(-1, -1, -1, -1, 1'b1, dk, vr);
        check("restart_done_k",  dk, 65);
        check("restart_writes",  wr_pulses, 16);
        check("restart_err_cnt", err_cycles, 0);
        check("restart_count",   {27'd0, count}, 16);
        @(negedge clk);
        #1;

        // Second start mid-batch is ignored but flagged.
        run_batch(-1, -1, -1, 20, 1'b0, dk, vr);
        check("dblstart_done_k",  dk, 65);
        check("dblstart_err_cnt", err_cycles, 1);
        check("dblstart_writes",  wr_pulses, 16);
        @(negedge clk);
        #1;

        // Asynchronous reset in LAUNCH, between clock edges.
        done_cycles = 0;
        dp_ready = 1'b0;
        res_valid = 1'b0;
        start = 1'b1;
        vr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            if (dp_valid) begin
                vr = 1;
                break;
            end
        end
        check("arst_reached_launch", vr, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy",       {31'd0, busy}, 0);
        check("arst_dp_valid",   {31'd0, dp_valid}, 0);
        check("arst_op_rd_addr", {28'd0, op_rd_addr}, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        dp_ready = 1'b1;
        res_valid = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("arst_no_done", done_cycles, 0);
        check("arst_idle",    {31'd0, busy}, 0);
        check("arst_count",   {27'd0, count}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dot_scheduler.md
DOT_SCHEDULER -- requirements
Module: dot_scheduler

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, width of operand/result memory address; number of entries N = 2**ADDRESS_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, width of each packed operand vector; used only for pass-through checks, not datapath logic.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to process all N entries.
REQ-006 SHALL have port abort, input, 1, cancel the running batch.
REQ-007 SHALL have port host_wr, input, 1, host operand-memory write request.
REQ-008 SHALL have port host_wr_ok, output, 1, host write grant to the operand memories.
REQ-009 SHALL have ports op_rd_en (output, 1) and op_rd_addr (output, ADDRESS_WIDTH), operand-memory read with 1-cycle latency.
REQ-010 SHALL have ports dp_valid (output, 1) and dp_ready (input, 1), launch handshake to dot-product datapath.
REQ-011 SHALL have ports res_valid (input, 1) and res_ready (output, 1), result handshake from datapath.
REQ-012 SHALL have ports res_wr_en (output, 1) and res_wr_addr (output, ADDRESS_WIDTH), result-memory write strobe.
REQ-013 SHALL have ports busy (output, 1), done_writing (output, 1, one-cycle pulse), err (output, 1, one-cycle pulse), count (output, ADDRESS_WIDTH+1, entries written this batch).

Function
REQ-014 SHALL implement FSM states IDLE, READ, LAUNCH, WAIT, WRITE, DONE.
REQ-015 IDLE: start=1 -> READ; addr counter and count cleared to 0 on that transition.
REQ-016 READ: op_rd_en=1, op_rd_addr=addr, exactly one cycle -> LAUNCH.
REQ-017 LAUNCH: dp_valid=1, held until dp_ready=1 sampled -> WAIT; dp_valid SHALL not drop before acceptance.
REQ-018 WAIT: res_ready=1 until res_valid=1 sampled -> WRITE.
REQ-019 WRITE: res_wr_en=1, res_wr_addr=addr, one cycle; count increments; addr=N-1 -> DONE, else addr+1 -> READ.
REQ-020 DONE: done_writing=1 for one cycle -> IDLE.
REQ-021 Minimum per-entry latency 4 cycles (dp_ready, res_valid already high); full batch minimum 4*N+1 cycles from start to done_writing.
REQ-022 busy=1 in every state except IDLE.
REQ-023 host_wr_ok = host_wr AND NOT busy (combinational); host writes never granted during a batch.
REQ-024 start while busy SHALL be ignored and SHALL pulse err one cycle.
REQ-025 host_wr while busy SHALL pulse err one cycle; start and host_wr both while busy -> single err pulse.
REQ-026 start and host_wr same cycle in IDLE: host_wr_ok=1 that cycle, batch begins next cycle.
REQ-027 abort in any non-IDLE state -> IDLE next cycle; no res_wr_en issued that cycle; no done_writing; count holds last value.
REQ-028 abort in IDLE has no effect; abort same cycle as start in IDLE -> start wins.
REQ-029 addr counter SHALL not wrap; count reaches exactly N at DONE.
REQ-030 res_valid outside WAIT SHALL be ignored; dp_ready outside LAUNCH ignored.

Reset
REQ-031 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-032 Reset values: all strobes/handshake outputs 0, busy 0, done_writing 0, err 0, count 0, op_rd_addr 0, res_wr_addr 0.
REQ-033 rst mid-batch SHALL discard progress; no done_writing on release.

Structure
REQ-034 State encoding enum and default ADDRESS_WIDTH/DATA_WIDTH/VALUE_WIDTH constants SHALL live in shared package dot_pkg.
REQ-035 SHALL be a single module; one sub-module allowed: dot_addr_cnt (addr/count counter with clear, enable, last flag).

Verification
REQ-036 Reset, start, dp_ready=1, res_valid=1 constant, N=16 -> 16 res_wr_en pulses addr 0..15, done_writing at cycle 65 after start, count=16.
REQ-037 dp_ready delayed 3 cycles at entry 5 -> dp_valid held 4 cycles, op_rd_addr unchanged, no extra writes.
REQ-038 host_wr=1 at entry 7 -> host_wr_ok=0, err one-cycle pulse; host_wr in IDLE -> host_wr_ok=1, err=0.
REQ-039 abort in WAIT of entry 9 -> IDLE next cycle, count=9, no done_writing; fresh start restarts at addr 0.
REQ-040 rst asserted mid-LAUNCH between clk edges -> busy=0 and dp_valid=0 before next edge.
REQ-041 start pulse while busy -> err pulse, batch timing unchanged, done_writing still at cycle 65.
